// File: rtl/cphy_lp_pkg.sv
// Shared C-PHY low-power definitions used by the TX and RX control logic.
//   - 2-bit LP control codes (same encoding on both sides of the link)
//   - 3-bit {A,B,C} line-state constants
//   - RX line-state FSM enum
//   - helpers to classify and encode a filtered line state
package cphy_lp_pkg;

    localparam logic [1:0] LP_STOP = 2'b00;
    localparam logic [1:0] LP_001  = 2'b01;
    localparam logic [1:0] LP_000  = 2'b10;
    localparam logic [1:0] LP_100  = 2'b11;

    localparam logic [2:0] LINE_111 = 3'b111;
    localparam logic [2:0] LINE_001 = 3'b001;
    localparam logic [2:0] LINE_000 = 3'b000;
    localparam logic [2:0] LINE_100 = 3'b100;

    typedef enum logic [3:0] {
        StIdle,
        StStop,
        StHsRq,
        StHsPrep,
        StHs,
        StLpRq,
        StLpYield,
        StEscRq,
        StEsc,
        StTaRq
    } lp_state_e;

    function automatic logic line_legal(input logic [2:0] line);
        return (line == LINE_111) || (line == LINE_001) ||
               (line == LINE_000) || (line == LINE_100);
    endfunction

    // Only meaningful for legal line states.
    function automatic logic [1:0] line_to_code(input logic [2:0] line);
        logic [1:0] code;
        case (line)
            LINE_001: code = LP_001;
            LINE_000: code = LP_000;
            LINE_100: code = LP_100;
            default:  code = LP_STOP;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/rx_lp_ctrl_logic_if.sv
// Bundle between the LP line receivers / lane controller and the RX LP decoder.
//   A, B, C     raw LP receiver outputs (asynchronous to the lane clock)
//   RxCtrlIn    decoded filtered LP code
//   lp_stop     level, lane in STOP
//   hs_active   level, HS entry completed
//   esc_active  level, escape entry completed
//   ta_req      one-cycle pulse, turnaround request decoded
//   seq_err     one-cycle pulse, illegal code / transition / timeout
// slave: the decoder; master: the environment driving the lines.
interface rx_lp_ctrl_logic_if;

    logic       A;
    logic       B;
    logic       C;
    logic [1:0] RxCtrlIn;
    logic       lp_stop;
    logic       hs_active;
    logic       esc_active;
    logic       ta_req;
    logic       seq_err;

    modport slave (
        input  A, B, C,
        output RxCtrlIn, lp_stop, hs_active, esc_active, ta_req, seq_err
    );

    modport master (
        output A, B, C,
        input  RxCtrlIn, lp_stop, hs_active, esc_active, ta_req, seq_err
    );

endinterface

// File: rtl/rx_lp_ctrl_logic_lp_line_filter.sv
// Synchronizer and glitch filter for the three LP line receivers.
//   clk        lane clock
//   rst        asynchronous, active-high reset
//   line_raw   {A,B,C} straight from the receivers
//   line_filt  filtered {A,B,C}; changes only after FILT_CYC stable cycles
module lp_line_filter
    import cphy_lp_pkg::*;
#(
    parameter int unsigned FILT_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] line_raw,
    output logic [2:0] line_filt
);

    localparam int unsigned CntW = $clog2(FILT_CYC) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(FILT_CYC - 1);

    logic [2:0]      sync1_q, sync2_q;
    logic [2:0]      cand_q;
    logic [2:0]      filt_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    // cnt counts cycles the candidate has matched since it was loaded; the
    // reload cycle itself is the first stable cycle, so FILT_CYC stable
    // cycles are reached when cnt_d hits FILT_CYC-1.
    always_comb begin
        cnt_d = cnt_q;
        if (sync2_q != cand_q) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= LINE_000;
            sync2_q <= LINE_000;
            cand_q  <= LINE_000;
            filt_q  <= LINE_000;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_raw;
            sync2_q <= sync1_q;
            cand_q  <= sync2_q;
            cnt_q   <= cnt_d;
            if (cnt_d == CntMax) begin
                filt_q <= sync2_q;
            end
        end
    end

    assign line_filt = filt_q;

endmodule

// File: rtl/rx_lp_ctrl_logic.sv
// Receive-side C-PHY LP line-state decoder.
// Filters the three LP receivers, decodes the filtered state to the 2-bit LP
// code and tracks the HS-entry, escape-entry and turnaround sequences.
//   clk, rst  lane clock and asynchronous active-high reset
//   lp        slave side of rx_lp_ctrl_logic_if (raw lines in, status out)
// All outputs are registered.
module rx_lp_ctrl_logic
    import cphy_lp_pkg::*;
#(
    parameter int unsigned FILT_CYC    = 4,
    parameter int unsigned HS_PREP_CYC = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    rx_lp_ctrl_logic_if.slave  lp
);

    localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC) + 1;
    localparam int unsigned PrepW = $clog2(HS_PREP_CYC) + 1;

    logic [2:0]       line_filt;
    logic [2:0]       filt_prev_q;
    lp_state_e        state_q, state_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic [PrepW-1:0] prep_q, prep_d;
    logic             err;
    logic             timed;
    logic             tmo_exp;
    logic             prep_done;

    logic [1:0] code_q, code_d;
    logic       lp_stop_q, hs_q, esc_q, ta_q, err_q;

    lp_line_filter #(
        .FILT_CYC (FILT_CYC)
    ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .line_raw  ({lp.A, lp.B, lp.C}),
        .line_filt (line_filt)
    );

    // Intermediate states that are bounded by the timeout.
    assign timed = (state_q == StHsRq)    || (state_q == StHsPrep) ||
                   (state_q == StLpRq)    || (state_q == StLpYield) ||
                   (state_q == StEscRq)   || (state_q == StTaRq);

    assign tmo_exp   = (tmo_q == TmoW'(TIMEOUT_CYC - 1));
    assign prep_done = (prep_q == PrepW'(HS_PREP_CYC - 1));

    // Level-based decode: holding the code that entered a state is not a
    // transition; anything else not listed for that state is an error.
    always_comb begin
        state_d = state_q;
        err     = 1'b0;
        if (line_filt == LINE_111) begin
            state_d = StStop;
        end else begin
            unique case (state_q)
                StIdle, StHs, StEsc: begin
                    // HS/ESC lines toggle freely; IDLE waits for STOP.
                end
                StStop: begin
                    if (line_filt == LINE_001)      state_d = StHsRq;
                    else if (line_filt == LINE_100) state_d = StLpRq;
                    else                            err = 1'b1;
                end
                StHsRq: begin
                    if (line_filt == LINE_000)      state_d = StHsPrep;
                    else if (line_filt != LINE_001) err = 1'b1;
                end
                StHsPrep: begin
                    if (line_filt != LINE_000)      err = 1'b1;
                    else if (prep_done)             state_d = StHs;
                end
                StLpRq: begin
                    if (line_filt == LINE_000)      state_d = StLpYield;
                    else if (line_filt != LINE_100) err = 1'b1;
                end
                StLpYield: begin
                    if (line_filt == LINE_001)      state_d = StEscRq;
                    else if (line_filt == LINE_100) state_d = StTaRq;
                    else if (line_filt != LINE_000) err = 1'b1;
                end
                StEscRq: begin
                    if (line_filt == LINE_000)      state_d = StEsc;
                    else if (line_filt != LINE_001) err = 1'b1;
                end
                StTaRq: begin
                    if (line_filt == LINE_000)      state_d = StIdle;
                    else if (line_filt != LINE_100) err = 1'b1;
                end
                default: err = 1'b1;
            endcase
            // A legal transition taken this cycle beats an expiring timeout.
            if (!err && timed && (state_d == state_q) && tmo_exp) begin
                err = 1'b1;
            end
            if (err) begin
                state_d = StIdle;
            end
        end
    end

    always_comb begin
        tmo_d  = '0;
        prep_d = '0;
        if (state_d == state_q) begin
            if (timed)               tmo_d  = tmo_q + 1'b1;
            if (state_q == StHsPrep) prep_d = prep_q + 1'b1;
        end
    end

    // The code tracks filtered changes only, so the reset-time filtered 000
    // does not show up on RxCtrlIn; illegal codes leave it holding.
    always_comb begin
        code_d = code_q;
        if ((line_filt != filt_prev_q) && line_legal(line_filt)) begin
            code_d = line_to_code(line_filt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            tmo_q       <= '0;
            prep_q      <= '0;
            filt_prev_q <= LINE_000;
            code_q      <= LP_STOP;
            lp_stop_q   <= 1'b0;
            hs_q        <= 1'b0;
            esc_q       <= 1'b0;
            ta_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            prep_q      <= prep_d;
            filt_prev_q <= line_filt;
            code_q      <= code_d;
            lp_stop_q   <= (state_d == StStop);
            hs_q        <= (state_d == StHs);
            esc_q       <= (state_d == StEsc);
            ta_q        <= (state_q == StLpYield) && (state_d == StTaRq);
            err_q       <= err;
        end
    end

    assign lp.RxCtrlIn   = code_q;
    assign lp.lp_stop    = lp_stop_q;
    assign lp.hs_active  = hs_q;
    assign lp.esc_active = esc_q;
    assign lp.ta_req     = ta_q;
    assign lp.seq_err    = err_q;

endmodule
